// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM state encoding, command record.
// Build option: ALU_CHAIN_EN (see alu_op_sequencer.sv).
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 32;
  localparam int SEQ_TAG_W  = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011,
    OP_MOD = 4'b0100, OP_AND = 4'b0101, OP_OR  = 4'b0110, OP_XOR = 4'b0111,
    OP_NOT = 4'b1000, OP_SHL = 4'b1001, OP_SHR = 4'b1010, OP_EQ  = 4'b1011,
    OP_LT  = 4'b1100, OP_GT  = 4'b1101, OP_SEL = 4'b1110, OP_ASR = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TOGGLE = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]            op;
    logic [SEQ_DATA_W-1:0] a;
    logic [SEQ_DATA_W-1:0] b;
    logic [SEQ_DATA_W-1:0] c;
    logic [SEQ_TAG_W-1:0]  tag;
    logic                  chain;
  } cmd_t;

  function automatic logic is_divop(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the sequencer (master) and its command source, result sink and ALU (slave).
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  // Valid/ready: a transfer happens on a rising edge where valid & ready are both high;
  // a producer holds valid and its payload stable until that edge, and ready never
  // depends on valid.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [DATA_W-1:0] cmd_c;
  logic [TAG_W-1:0]  cmd_tag;
  logic              cmd_chain;

  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_c;
  logic [DATA_W-1:0] alu_d;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_err;

  logic              busy;
  logic [1:0]        dbg_state;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_tag, cmd_chain, alu_d, res_ready,
    output cmd_ready, alu_ctrl, alu_a, alu_b, alu_c,
           res_valid, res_data, res_tag, res_err, busy, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, cmd_tag, cmd_chain, alu_d, res_ready,
    input  cmd_ready, alu_ctrl, alu_a, alu_b, alu_c,
           res_valid, res_data, res_tag, res_err, busy, dbg_state
  );
endinterface

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// Command FIFO: power-of-two depth, extra-MSB pointers so full/empty need no counter.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Issues buffered commands to an external ALU one at a time and returns results in order.
// Build option: `ALU_CHAIN_EN adds an accumulator that can replace operand a.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W     = SEQ_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1,
  parameter int TAG_W      = SEQ_TAG_W
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.master bus
);
  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [TAG_W-1:0]  tag;
    logic              chain;
  } seq_cmd_t;

  localparam int         CMD_W    = $bits(seq_cmd_t);
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);
  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] TOGGLE   = ST_TOGGLE;
  localparam logic [1:0] ISSUE    = ST_ISSUE;
  localparam logic [1:0] RESP     = ST_RESP;

  logic [1:0]        state_q, state_d;
  seq_cmd_t          cur_q, cur_d;
  logic [3:0]        lat_q, lat_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_c_q, alu_c_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              res_err_q, res_err_d;

  seq_cmd_t          push_cmd, head;
  logic [CMD_W-1:0]  head_flat;
  logic              push, pop, full, empty;
  logic [DATA_W-1:0] head_a, cur_a;

  assign push_cmd = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, c: bus.cmd_c,
                      tag: bus.cmd_tag, chain: bus.cmd_chain};
  assign push     = bus.cmd_valid && !full;
  assign head     = seq_cmd_t'(head_flat);

  alu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (head_flat),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef ALU_CHAIN_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  assign head_a = head.chain  ? acc_q : head.a;
  assign cur_a  = cur_q.chain ? acc_q : cur_q.a;
`else
  logic chain_unused;
  assign head_a       = head.a;
  assign cur_a        = cur_q.a;
  assign chain_unused = head.chain ^ cur_q.chain;
`endif

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    lat_d      = lat_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_c_d    = alu_c_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;
    res_err_d  = res_err_q;
    pop        = 1'b0;
`ifdef ALU_CHAIN_EN
    acc_d      = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cur_d = head;
          // Divide-by-zero never reaches the ALU; ports keep their previous values.
          if (is_divop(head.op) && (head.b == '0)) begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            res_tag_d  = head.tag;
            state_d    = RESP;
          end else if (head.op == alu_ctrl_q) begin
            // The ALU only re-evaluates on a ctrl change, so force one.
            alu_ctrl_d = ~head.op;
            state_d    = TOGGLE;
          end else begin
            alu_ctrl_d = head.op;
            alu_a_d    = head_a;
            alu_b_d    = head.b;
            alu_c_d    = head.c;
            lat_d      = LAT_INIT;
            state_d    = ISSUE;
          end
        end
      end
      TOGGLE: begin
        alu_ctrl_d = cur_q.op;
        alu_a_d    = cur_a;
        alu_b_d    = cur_q.b;
        alu_c_d    = cur_q.c;
        lat_d      = LAT_INIT;
        state_d    = ISSUE;
      end
      ISSUE: begin
        if (lat_q == 4'd0) begin
          res_data_d = bus.alu_d;
          res_tag_d  = cur_q.tag;
          res_err_d  = 1'b0;
`ifdef ALU_CHAIN_EN
          acc_d      = bus.alu_d;
`endif
          state_d    = RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      lat_q      <= '0;
      alu_ctrl_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_c_q    <= '0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      lat_q      <= lat_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_c_q    <= alu_c_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
      res_err_q  <= res_err_d;
    end
  end

`ifdef ALU_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`endif

  assign bus.cmd_ready = !full;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_c     = alu_c_q;
  assign bus.res_valid = (state_q == RESP);
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = (state_q != IDLE) || !empty;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a ctrl-change-triggered ALU model.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_op_sequencer_if #(.DATA_W(32), .TAG_W(4)) bus ();

  alu_op_sequencer #(.DATA_W(32), .FIFO_DEPTH(4), .ALU_LAT(1), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, b, c);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b != 0) ? 32'($signed(a) / $signed(b)) : 32'd0;
      4'd4:    return (b != 0) ? 32'($signed(a) % $signed(b)) : 32'd0;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return ~a;
      4'd9:    return a << b[4:0];
      4'd10:   return a >> b[4:0];
      4'd11:   return {31'd0, a == b};
      4'd12:   return {31'd0, $signed(a) < $signed(b)};
      4'd13:   return {31'd0, $signed(a) > $signed(b)};
      4'd14:   return c[0] ? b : a;
      default: return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  // The modelled ALU only recomputes when ctrl changes.
  initial bus.alu_d = '0;
  always @(bus.alu_ctrl) begin
    #1 bus.alu_d = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_c);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, b, c,
                      input logic [3:0] tag, input logic chain);
    int n = 0;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_c = c;
    bus.cmd_tag = tag; bus.cmd_chain = chain; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", bus.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic pop_res(input string tag, input logic [31:0] exp_data,
                         input logic [3:0] exp_tag, input logic exp_err);
    int n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.res_valid, 1);
    chk({tag, "_data"}, bus.res_data, exp_data);
    chk({tag, "_tag"}, bus.res_tag, exp_tag);
    chk({tag, "_err"}, bus.res_err, exp_err);
    release_res();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_c = '0; bus.cmd_tag = '0; bus.cmd_chain = 1'b0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_alu_ctrl", bus.alu_ctrl, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", bus.dbg_state, 0);

    // 1: reset while ISSUE is in progress with one command still queued
    push(4'd1, 32'd7, 32'd2, 32'd0, 4'd1, 1'b0);
    push(4'd2, 32'd3, 32'd3, 32'd0, 4'd2, 1'b0);
    chk("t1_state_issue", bus.dbg_state, 2);
    chk("t1_ctrl_pre", bus.alu_ctrl, 4'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_res_valid", bus.res_valid, 0);
    chk("t1_alu_ctrl", bus.alu_ctrl, 0);
    chk("t1_cmd_ready", bus.cmd_ready, 1);
    chk("t1_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_lost_busy", bus.busy, 0);
    chk("t1_lost_valid", bus.res_valid, 0);
    chk("t1_lost_state", bus.dbg_state, 0);

    // 2: SUB 9-4, two-cycle latency, no toggle after reset
    push(4'd1, 32'd9, 32'd4, 32'd0, 4'd3, 1'b0);
    chk("t2_valid_e0", bus.res_valid, 0);
    chk("t2_busy", bus.busy, 1);
    @(negedge clk);
    chk("t2_valid_e1", bus.res_valid, 0);
    chk("t2_ctrl", bus.alu_ctrl, 4'd1);
    chk("t2_alu_a", bus.alu_a, 32'd9);
    chk("t2_alu_b", bus.alu_b, 32'd4);
    @(negedge clk);
    chk("t2_valid_e2", bus.res_valid, 1);
    pop_res("t2", 32'd5, 4'd3, 1'b0);
    chk("t2_valid_after", bus.res_valid, 0);

    // 3: MUL then MUL again; second one must toggle ctrl
    push(4'd2, 32'd3, 32'd4, 32'd0, 4'd4, 1'b0);
    push(4'd2, 32'd5, 32'd6, 32'd0, 4'd5, 1'b0);
    chk("t3_ctrl_first", bus.alu_ctrl, 4'b0010);
    pop_res("t3a", 32'd12, 4'd4, 1'b0);
    @(negedge clk);
    chk("t3_ctrl_toggle", bus.alu_ctrl, 4'b1101);
    chk("t3_state_toggle", bus.dbg_state, 1);
    @(negedge clk);
    chk("t3_ctrl_second", bus.alu_ctrl, 4'b0010);
    pop_res("t3b", 32'd30, 4'd5, 1'b0);

    // 4: DIV by zero is answered without touching the ALU
    push(4'd3, 32'd8, 32'd0, 32'd0, 4'd9, 1'b0);
    chk("t4_valid_e0", bus.res_valid, 0);
    @(negedge clk);
    chk("t4_valid_e1", bus.res_valid, 1);
    chk("t4_ctrl", bus.alu_ctrl, 4'b0010);
    chk("t4_alu_a", bus.alu_a, 32'd5);
    pop_res("t4", 32'd0, 4'd9, 1'b1);

    // 5: backpressure; 1 in flight plus 4 queued, sixth push refused
    for (int k = 1; k <= 5; k++)
      push(4'd0, 32'(k * 10), 32'(k), 32'd0, 4'(k), 1'b0);
    chk("t5_full_ready", bus.cmd_ready, 0);
    bus.cmd_op = 4'd0; bus.cmd_a = 32'd600; bus.cmd_b = 32'd6; bus.cmd_tag = 4'd6;
    bus.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_still_full", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++)
      pop_res("t5", 32'(k * 11), 4'(k), 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_drained_valid", bus.res_valid, 0);
    chk("t5_drained_busy", bus.busy, 0);

    // 6: chained MUL uses the previous result only when the accumulator is built in
    push(4'd0, 32'd2, 32'd3, 32'd0, 4'd1, 1'b0);
    push(4'd2, 32'd7, 32'd4, 32'd0, 4'd2, 1'b1);
    pop_res("t6a", 32'd5, 4'd1, 1'b0);
`ifdef ALU_CHAIN_EN
    pop_res("t6b", 32'd20, 4'd2, 1'b0);
`else
    pop_res("t6b", 32'd28, 4'd2, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
